// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier datapath.
// It sequences clear, operand load, WIDTH evaluate/shift iterations and a two-cycle result read-out.
module booth_controller #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic x0,
  input  logic e0,
  output logic ldY,
  output logic ldX,
  output logic clrA,
  output logic clrE,
  output logic ldA,
  output logic sub,
  output logic shA,
  output logic shX,
  output logic ldE,
  output logic sel,
  output logic busy,
  output logic valid,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LDY    = 3'd2,
    LDX    = 3'd3,
    EVAL   = 3'd4,
    SHIFT  = 3'd5,
    OUT_HI = 3'd6,
    OUT_LO = 3'd7
  } state_t;

  typedef struct packed {
    logic ld_y;
    logic ld_x;
    logic clr_a;
    logic clr_e;
    logic sh_a;
    logic sh_x;
    logic ld_e;
    logic sel;
    logic busy;
    logic valid;
    logic done;
  } strobes_t;

  state_t           state;
  strobes_t         strb;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

  function automatic state_t next_state(input state_t s, input logic go, input logic last);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:    n = go ? CLR : IDLE;
      CLR:     n = LDY;
      LDY:     n = LDX;
      LDX:     n = EVAL;
      EVAL:    n = SHIFT;
      SHIFT:   n = last ? OUT_HI : EVAL;
      OUT_HI:  n = OUT_LO;
      OUT_LO:  n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Strobe pattern owned by each state; an unknown code decodes to all-zero.
  function automatic strobes_t decode(input state_t s);
    strobes_t o;
    o = '0;
    o.busy = (s != IDLE);
    case (s)
      CLR: begin
        o.clr_a = 1'b1;
        o.clr_e = 1'b1;
      end
      LDY:   o.ld_y = 1'b1;
      LDX:   o.ld_x = 1'b1;
      SHIFT: begin
        o.sh_a = 1'b1;
        o.sh_x = 1'b1;
        o.ld_e = 1'b1;
      end
      OUT_HI: begin
        o.sel   = 1'b1;
        o.valid = 1'b1;
      end
      OUT_LO: begin
        o.valid = 1'b1;
        o.done  = 1'b1;
      end
      IDLE, EVAL: ;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Outputs are registered alongside the state so they always match the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      strb  <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state(state, start, cnt_last);
      strb  <= decode(next_state(state, start, cnt_last));
      case (state)
        LDX:     cnt <= '0;
        SHIFT:   cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Recoding pair {x0,e0}: 10 subtracts Y, 01 adds Y, 00/11 skip the ALU write.
  assign ldA = (state == EVAL) & (x0 ^ e0);
  assign sub = (state == EVAL) & x0 & ~e0;

  assign ldY   = strb.ld_y;
  assign ldX   = strb.ld_x;
  assign clrA  = strb.clr_a;
  assign clrE  = strb.clr_e;
  assign shA   = strb.sh_a;
  assign shX   = strb.sh_x;
  assign ldE   = strb.ld_e;
  assign sel   = strb.sel;
  assign busy  = strb.busy;
  assign valid = strb.valid;
  assign done  = strb.done;

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller with a 4-bit Booth datapath model
// that closes the x0/e0 loop and produces data_out.
module tb_booth_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic x0, e0;
  logic ldY, ldX, clrA, clrE, ldA, sub, shA, shX, ldE, sel, busy, valid, done;

  int n_cmp = 0;
  int n_err = 0;

  // Output word layout: {ldY,ldX,clrA,clrE,ldA,sub,shA,shX,ldE,sel,busy,valid,done}
  localparam logic [12:0] W_IDLE  = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] W_CLR   = 13'b0_0_1_1_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] W_LDY   = 13'b1_0_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] W_LDX   = 13'b0_1_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] W_EVAL  = 13'b0_0_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] W_SHIFT = 13'b0_0_0_0_0_0_1_1_1_0_1_0_0;
  localparam logic [12:0] W_OUTHI = 13'b0_0_0_0_0_0_0_0_0_1_1_1_0;
  localparam logic [12:0] W_OUTLO = 13'b0_0_0_0_0_0_0_0_0_0_1_1_1;

  logic [12:0] obs;
  assign obs = {ldY, ldX, clrA, clrE, ldA, sub, shA, shX, ldE, sel, busy, valid, done};

  booth_controller #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .e0(e0),
    .ldY(ldY), .ldX(ldX), .clrA(clrA), .clrE(clrE), .ldA(ldA), .sub(sub),
    .shA(shA), .shX(shX), .ldE(ldE), .sel(sel), .busy(busy), .valid(valid), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: A, X, Y registers and the E flop.
  logic [3:0] op_x, op_y, data_in, data_out;
  logic [3:0] a_r, x_r, y_r;
  logic       e_r;

  assign data_in  = ldX ? op_x : op_y;
  assign data_out = sel ? a_r : x_r;
  assign x0       = x_r[0];
  assign e0       = e_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      x_r <= '0;
      y_r <= '0;
      e_r <= 1'b0;
    end else begin
      if (clrA) a_r <= '0;
      if (clrE) e_r <= 1'b0;
      if (ldY)  y_r <= data_in;
      if (ldX)  x_r <= data_in;
      if (ldA)  a_r <= sub ? (a_r - y_r) : (a_r + y_r);
      if (shA)  a_r <= {a_r[3], a_r[3:1]};
      if (shX)  x_r <= {a_r[0], x_r[3:1]};
      if (ldE)  e_r <= x_r[0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // mode 0: single start pulse; 1: start held high throughout; 2: start toggled high while busy.
  task automatic run_mult(input string tag, input logic [3:0] xv, input logic [3:0] yv,
                          input logic [7:0] ops, input logic [3:0] hi, input logic [3:0] lo,
                          input int mode);
    logic [1:0] op;
    op_x  = xv;
    op_y  = yv;
    start = 1'b1;
    step(); check({tag, "/clr"}, 32'(obs), 32'(W_CLR));
    start = (mode != 0);
    step(); check({tag, "/ldy"}, 32'(obs), 32'(W_LDY));
    step(); check({tag, "/ldx"}, 32'(obs), 32'(W_LDX));
    for (int i = 0; i < 4; i++) begin
      op = ops[7 - 2*i -: 2];
      step(); check($sformatf("%s/eval%0d", tag, i + 1), 32'(obs), 32'(W_EVAL | (13'(op) << 7)));
      step(); check($sformatf("%s/shift%0d", tag, i + 1), 32'(obs), 32'(W_SHIFT));
    end
    step();
    check({tag, "/out_hi"}, 32'(obs), 32'(W_OUTHI));
    check({tag, "/data_hi"}, 32'(data_out), 32'(hi));
    step();
    check({tag, "/out_lo"}, 32'(obs), 32'(W_OUTLO));
    check({tag, "/data_lo"}, 32'(data_out), 32'(lo));
    if (mode == 2) start = 1'b0;
    step(); check({tag, "/idle"}, 32'(obs), 32'(W_IDLE));
    if (mode != 1) begin
      step(); check({tag, "/idle2"}, 32'(obs), 32'(W_IDLE));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_x  = '0;
    op_y  = '0;
    step();
    check("reset", 32'(obs), 32'(W_IDLE));
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'(obs), 32'(W_IDLE));

    // Reset asserted in the middle of the first SHIFT.
    op_x  = 4'b1101;
    op_y  = 4'b1010;
    start = 1'b1;
    step(); check("mid/clr", 32'(obs), 32'(W_CLR));
    start = 1'b0;
    step(); check("mid/ldy", 32'(obs), 32'(W_LDY));
    step(); check("mid/ldx", 32'(obs), 32'(W_LDX));
    step(); check("mid/eval1", 32'(obs), 32'(W_EVAL | (13'(2'b11) << 7)));
    step(); check("mid/shift1", 32'(obs), 32'(W_SHIFT));
    #2 rst_n = 1'b0;
    #1 check("mid/async_reset", 32'(obs), 32'(W_IDLE));
    step();
    rst_n = 1'b1;
    step(); check("mid/idle", 32'(obs), 32'(W_IDLE));

    // -3 * -6 = +18: recoding sub, add, sub, skip.
    run_mult("neg_neg", 4'b1101, 4'b1010, 8'b11_10_11_00, 4'b0001, 4'b0010, 0);
    // X=0000: pairs all 00, no ALU writes.
    run_mult("zero_x", 4'b0000, 4'b0111, 8'b00_00_00_00, 4'b0000, 4'b0000, 0);
    // X=1111: first pair 10 (E cleared), then 11 throughout; -1 * 3 = -3.
    run_mult("ones_x", 4'b1111, 4'b0011, 8'b11_00_00_00, 4'b1111, 4'b1101, 0);
    // start held high: restart after exactly one IDLE cycle; 5 * 3 = 15.
    run_mult("hold_a", 4'b0101, 4'b0011, 8'b11_10_11_10, 4'b0000, 4'b1111, 1);
    run_mult("hold_b", 4'b1101, 4'b1010, 8'b11_10_11_00, 4'b0001, 4'b0010, 0);
    // start high during busy is ignored.
    run_mult("noise", 4'b0101, 4'b0011, 8'b11_10_11_10, 4'b0000, 4'b1111, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
